// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: widths, opcodes, FSM states and opcode classification shared by the sequencer, its decoder and the bench
package alu_sequencer_pkg;
  localparam int DATA_W = 16;
  localparam int OP_W = 4;
  localparam logic [OP_W-1:0] OP_NOP = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [OP_W-1:0] OP_XOR = 4'd3;
  localparam logic [OP_W-1:0] OP_MUL = 4'd4;
  typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} state_t;
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return op == OP_ADD || op == OP_SUB || op == OP_XOR || op == OP_MUL;
  endfunction
endpackage

// File: rtl/alu_sequencer_ctrl_decode.sv
// alu_ctrl_decode: maps FSM state and latched opcode to the one-hot ALU strobes
module alu_ctrl_decode
  import alu_sequencer_pkg::*;
(
  input  state_t          state,
  input  logic [OP_W-1:0] op,
  output logic            a_enable,
  output logic            addsub,
  output logic            xor_ctrl,
  output logic            mul_out_ctrl,
  output logic            acc_enable
);
  always_comb begin
    a_enable = state == LOAD && is_alu_op(op);
    acc_enable = state == EXEC && is_alu_op(op);
    addsub = acc_enable && op == OP_SUB;
    xor_ctrl = acc_enable && op == OP_XOR;
    mul_out_ctrl = acc_enable && op == OP_MUL;
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU operation per handshake, sequences the ALU strobes, returns result/status with backpressure
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [DATA_W-1:0] instr_a,
  input  logic [DATA_W-1:0] instr_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              a_enable,
  output logic              addsub,
  output logic              xor_ctrl,
  output logic              mul_out_ctrl,
  output logic              acc_enable,
  input  logic [DATA_W-1:0] acc_out,
  input  logic [3:0]        status_reg,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] result_data,
  output logic [3:0]        result_status,
  output logic              result_err,
  output logic [15:0]       op_count
);
  state_t state, state_d;
  logic [OP_W-1:0] lat_op;
  logic [DATA_W-1:0] lat_a, lat_b;
  logic accept;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_d;
  always_comb begin
    instr_ready = state == IDLE;
    accept = instr_valid && instr_ready;
    result_valid = state == RESP;
    state_d = state == IDLE ? (accept ? (is_alu_op(instr_op) ? LOAD : RESP) : IDLE)
            : state == LOAD ? EXEC
            : state == EXEC ? RESP
            : result_ready ? IDLE : RESP;
    alu_a = state == LOAD ? lat_a : '0;
    alu_b = state == EXEC ? lat_b : '0;
    result_data = result_valid ? acc_out : '0;
  end
  // NOP/illegal ops never reach EXEC, so their status stays cleared from accept
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      lat_op <= OP_NOP;
      lat_a <= '0;
      lat_b <= '0;
      result_err <= 1'b0;
      result_status <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        lat_op <= instr_op;
        lat_a <= instr_a;
        lat_b <= instr_b;
        result_err <= !is_alu_op(instr_op) && instr_op != OP_NOP;
        result_status <= '0;
      end
      if (state == EXEC) result_status <= status_reg;
      if (state == RESP && result_ready) op_count <= op_count + 16'd1;
    end
  alu_ctrl_decode u_decode (
    .state(state),
    .op(lat_op),
    .a_enable(a_enable),
    .addsub(addsub),
    .xor_ctrl(xor_ctrl),
    .mul_out_ctrl(mul_out_ctrl),
    .acc_enable(acc_enable)
  );
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized and directed checks of alu_sequencer against a transaction-level model, with a simple ALU stub
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;
  logic clk = 0, rst = 0;
  logic instr_valid = 0, instr_ready;
  logic [3:0] instr_op = 0;
  logic [15:0] instr_a = 0, instr_b = 0;
  logic [15:0] alu_a, alu_b;
  logic a_enable, addsub, xor_ctrl, mul_out_ctrl, acc_enable;
  logic [15:0] acc_out = 0;
  logic [3:0] status_reg;
  logic result_valid, result_ready = 1;
  logic [15:0] result_data;
  logic [3:0] result_status;
  logic result_err;
  logic [15:0] op_count;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  alu_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_a(instr_a), .instr_b(instr_b),
    .alu_a(alu_a), .alu_b(alu_b), .a_enable(a_enable), .addsub(addsub),
    .xor_ctrl(xor_ctrl), .mul_out_ctrl(mul_out_ctrl), .acc_enable(acc_enable),
    .acc_out(acc_out), .status_reg(status_reg), .result_valid(result_valid),
    .result_ready(result_ready), .result_data(result_data),
    .result_status(result_status), .result_err(result_err), .op_count(op_count)
  );
  function automatic logic [3:0] stat_of(input logic [15:0] r);
    return {r == 16'h0, r[15], ^r, r[0]};
  endfunction
  function automatic logic [15:0] ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    return op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_XOR ? a ^ b : p[15:0];
  endfunction
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
  endtask
  // ALU stub: A register, accumulator, combinational status of the selected result
  logic [15:0] a_reg = 0, alu_res;
  logic [31:0] prod;
  always_comb begin
    prod = {16'h0, a_reg} * {16'h0, alu_b};
    alu_res = mul_out_ctrl ? prod[15:0] : xor_ctrl ? a_reg ^ alu_b : addsub ? a_reg - alu_b : a_reg + alu_b;
    status_reg = stat_of(alu_res);
  end
  always @(posedge clk) begin
    if (a_enable) a_reg <= alu_a;
    if (acc_enable) acc_out <= alu_res;
  end
  // transaction model: m_k counts cycles since the accept edge
  logic m_busy = 0, m_legal = 0, m_err = 0, preload = 0;
  int m_k = 0;
  logic [3:0] m_op = 0;
  logic [15:0] m_a = 0, m_b = 0, m_res = 0, m_cnt = 0;
  logic e_valid, e_aen, e_accen;
  always_comb begin
    e_valid = m_busy && (m_legal ? m_k >= 2 : 1'b1);
    e_aen = m_busy && m_legal && m_k == 0;
    e_accen = m_busy && m_legal && m_k == 1;
  end
  always @(posedge clk) begin
    if (!rst) begin
      m_busy <= 0;
      m_cnt <= 0;
    end else if (preload) m_cnt <= 16'hFFFF;
    else if (m_busy) begin
      if (e_valid && result_ready) begin
        m_busy <= 0;
        m_cnt <= m_cnt + 16'd1;
      end else m_k <= m_k + 1;
    end else if (instr_valid) begin
      m_busy <= 1;
      m_k <= 0;
      m_op <= instr_op;
      m_a <= instr_a;
      m_b <= instr_b;
      m_legal <= is_alu_op(instr_op);
      m_err <= !is_alu_op(instr_op) && instr_op != OP_NOP;
      m_res <= ref_op(instr_op, instr_a, instr_b);
    end
  end
  always @(negedge clk) if (rst && !preload) begin
    check("instr_ready", {31'b0, instr_ready}, {31'b0, !m_busy});
    check("result_valid", {31'b0, result_valid}, {31'b0, e_valid});
    check("a_enable", {31'b0, a_enable}, {31'b0, e_aen});
    check("alu_a", {16'b0, alu_a}, {16'b0, e_aen ? m_a : 16'h0});
    check("acc_enable", {31'b0, acc_enable}, {31'b0, e_accen});
    check("alu_b", {16'b0, alu_b}, {16'b0, e_accen ? m_b : 16'h0});
    check("addsub", {31'b0, addsub}, {31'b0, e_accen && m_op == OP_SUB});
    check("xor_ctrl", {31'b0, xor_ctrl}, {31'b0, e_accen && m_op == OP_XOR});
    check("mul_out_ctrl", {31'b0, mul_out_ctrl}, {31'b0, e_accen && m_op == OP_MUL});
    check("op_count", {16'b0, op_count}, {16'b0, m_cnt});
    if (e_valid) begin
      check("result_data", {16'b0, result_data}, {16'b0, m_legal ? m_res : acc_out});
      check("result_err", {31'b0, result_err}, {31'b0, m_err});
      if (m_legal) check("result_status", {28'b0, result_status}, {28'b0, stat_of(m_res)});
    end
  end
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #2;
    instr_valid = 1; instr_op = op; instr_a = a; instr_b = b;
    @(posedge clk); #2;
    instr_valid = 0;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (result_valid) begin
        n = i;
        return;
      end
    end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_ready) return;
    end
    check("idle_timeout", 0, 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    #1;
    check("reset_ready", {31'b0, instr_ready}, 1);
    check("reset_valid", {31'b0, result_valid}, 0);
    check("reset_count", {16'b0, op_count}, 0);
    send(OP_ADD, 16'h0003, 16'h0004);
    wait_valid(n);
    check("add_latency", n, 3);
    check("add_data", {16'b0, result_data}, 32'h7);
    @(negedge clk);
    check("add_count", {16'b0, op_count}, 1);
    send(OP_SUB, 16'h0005, 16'h0005);
    wait_valid(n);
    check("sub_data", {16'b0, result_data}, 0);
    check("sub_zero_flag", {31'b0, result_status[3]}, 1);
    wait_idle();
    result_ready = 0;
    send(OP_XOR, 16'hFF00, 16'h0FF0);
    wait_valid(n);
    check("xor_data", {16'b0, result_data}, 32'hF0F0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("xor_hold_valid", {31'b0, result_valid}, 1);
      check("xor_hold_data", {16'b0, result_data}, 32'hF0F0);
      check("xor_hold_ready", {31'b0, instr_ready}, 0);
    end
    result_ready = 1;
    wait_idle();
    send(4'hF, 16'h1111, 16'h2222);
    wait_valid(n);
    check("illegal_latency", n, 1);
    check("illegal_err", {31'b0, result_err}, 1);
    wait_idle();
    send(OP_NOP, 16'h0, 16'h0);
    wait_valid(n);
    check("nop_err", {31'b0, result_err}, 0);
    wait_idle();
    send(OP_MUL, 16'h0007, 16'h0009);
    @(negedge clk);
    @(posedge clk); #2;
    rst = 0;
    #1;
    check("rst_acc_enable", {31'b0, acc_enable}, 0);
    check("rst_mul_ctrl", {31'b0, mul_out_ctrl}, 0);
    check("rst_alu_b", {16'b0, alu_b}, 0);
    check("rst_valid", {31'b0, result_valid}, 0);
    check("rst_count", {16'b0, op_count}, 0);
    @(posedge clk); #2 rst = 1;
    send(OP_ADD, 16'h1234, 16'h0101);
    wait_valid(n);
    check("post_rst_add", {16'b0, result_data}, 32'h1335);
    @(negedge clk);
    check("post_rst_count", {16'b0, op_count}, 1);
    wait_idle();
    @(posedge clk); #2;
    force dut.op_count = 16'hFFFF;
    preload = 1;
    @(posedge clk); #1;
    release dut.op_count;
    preload = 0;
    @(negedge clk);
    check("preload_count", {16'b0, op_count}, 32'hFFFF);
    send(OP_ADD, 16'h0001, 16'h0001);
    wait_valid(n);
    @(negedge clk);
    check("wrap_count", {16'b0, op_count}, 0);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      instr_valid = ($urandom % 3) != 0;
      instr_op = ($urandom % 8 == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      instr_a = 16'($urandom);
      instr_b = 16'($urandom);
      result_ready = ($urandom % 4) != 0;
    end
    @(posedge clk); #2;
    instr_valid = 0;
    result_ready = 1;
    wait_idle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
